// File: rtl/conditional_negator_pipe_if.sv
// Handshake and data bundle between the upstream source, the negator pipe and the downstream sink.
interface conditional_negator_pipe_if #(
    parameter int unsigned DataSize = 8,
    parameter int unsigned Lanes    = 4
);
    logic [Lanes*DataSize-1:0] InData;
    logic [1:0]                Mode;
    logic [Lanes-1:0]          LaneMask;
    logic                      InValid;
    logic                      InReady;
    logic [Lanes*DataSize-1:0] OutData;
    logic [Lanes-1:0]          OutOvf;
    logic                      OutValid;
    logic                      OutReady;

    // Environment side: produces input words and consumes results.
    modport master (
        output InData, Mode, LaneMask, InValid, OutReady,
        input  InReady, OutData, OutOvf, OutValid
    );

    // Pipe side.
    modport slave (
        input  InData, Mode, LaneMask, InValid, OutReady,
        output InReady, OutData, OutOvf, OutValid
    );
endinterface

// File: rtl/conditional_negator_pipe.sv
// Two-stage, per-lane conditional negate / abs / ones-complement with valid-ready flow control.
module conditional_negator_pipe #(
    parameter int unsigned DataSize = 8,
    parameter int unsigned Lanes    = 4,
    parameter bit          Sat      = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    conditional_negator_pipe_if.slave bus
);
    localparam int unsigned Width = Lanes * DataSize;

    localparam logic [1:0] ModePass = 2'b00;
    localparam logic [1:0] ModeNeg  = 2'b01;
    localparam logic [1:0] ModeAbs  = 2'b10;
    localparam logic [1:0] ModeInv  = 2'b11;

    localparam logic [DataSize-1:0] LaneMin = {1'b1, {(DataSize-1){1'b0}}};
    localparam logic [DataSize-1:0] LaneMax = {1'b0, {(DataSize-1){1'b1}}};

    // Stage 1: captured operands
    logic             r_v1;
    logic [Width-1:0] r_s1_data;
    logic [1:0]       r_s1_mode;
    logic [Lanes-1:0] r_s1_mask;

    // Stage 2: results
    logic             r_v2;
    logic [Width-1:0] r_s2_data;
    logic [Lanes-1:0] r_s2_ovf;

    logic             w_en1;
    logic             w_en2;
    logic [Width-1:0] w_result;
    logic [Lanes-1:0] w_ovf;

    // A stage may load when it is empty or the stage after it is moving.
    assign w_en2 = !r_v2 || bus.OutReady;
    assign w_en1 = !r_v1 || w_en2;

    assign bus.InReady  = w_en1;
    assign bus.OutValid = r_v2;
    assign bus.OutData  = r_s2_data;
    assign bus.OutOvf   = r_s2_ovf;

    for (genvar k = 0; k < Lanes; k++) begin : g_lane
        logic [DataSize-1:0] w_x;
        logic [DataSize-1:0] w_neg;
        logic [DataSize-1:0] w_res;
        logic                w_lane_ovf;

        assign w_x   = r_s1_data[k*DataSize +: DataSize];
        assign w_neg = DataSize'(~w_x + 1'b1);

        // Lane result; only the most negative value can overflow under negate/abs.
        always_comb begin
            w_res      = w_x;
            w_lane_ovf = 1'b0;
            if (r_s1_mask[k]) begin
                case (r_s1_mode)
                    ModePass: w_res = w_x;
                    ModeNeg:  w_res = w_neg;
                    ModeAbs:  w_res = w_x[DataSize-1] ? w_neg : w_x;
                    ModeInv:  w_res = ~w_x;
                    default:  w_res = w_x;
                endcase
                if ((r_s1_mode == ModeNeg || r_s1_mode == ModeAbs) && w_x == LaneMin) begin
                    w_lane_ovf = 1'b1;
                    w_res      = Sat ? LaneMax : LaneMin;
                end
            end
        end

        assign w_result[k*DataSize +: DataSize] = w_res;
        assign w_ovf[k]                         = w_lane_ovf;
    end

    // Pipeline registers; reset flushes both stages.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_v1      <= 1'b0;
            r_s1_data <= '0;
            r_s1_mode <= 2'b00;
            r_s1_mask <= '0;
            r_v2      <= 1'b0;
            r_s2_data <= '0;
            r_s2_ovf  <= '0;
        end else begin
            if (w_en1) begin
                r_v1      <= bus.InValid;
                r_s1_data <= bus.InData;
                r_s1_mode <= bus.Mode;
                r_s1_mask <= bus.LaneMask;
            end
            if (w_en2) begin
                r_v2      <= r_v1;
                r_s2_data <= w_result;
                r_s2_ovf  <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_conditional_negator_pipe.sv
// Bench for conditional_negator_pipe: wrap and saturate instances driven in lockstep against a lane model.
module tb_conditional_negator_pipe;
    localparam int unsigned DS   = 8;
    localparam int unsigned L    = 4;
    localparam int unsigned W    = DS * L;
    localparam int          MAXV = (1 << (DS - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data;
    logic [1:0]   mode;
    logic [L-1:0] mask;
    logic         in_valid;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    logic [W+L-1:0] q0[$];
    logic [W+L-1:0] q1[$];

    always #5 clk = ~clk;

    conditional_negator_pipe_if #(.DataSize(DS), .Lanes(L)) bus0();
    conditional_negator_pipe_if #(.DataSize(DS), .Lanes(L)) bus1();

    assign bus0.InData   = in_data;
    assign bus0.Mode     = mode;
    assign bus0.LaneMask = mask;
    assign bus0.InValid  = in_valid;
    assign bus0.OutReady = out_ready;
    assign bus1.InData   = in_data;
    assign bus1.Mode     = mode;
    assign bus1.LaneMask = mask;
    assign bus1.InValid  = in_valid;
    assign bus1.OutReady = out_ready;

    conditional_negator_pipe #(.DataSize(DS), .Lanes(L), .Sat(1'b0)) dut0 (
        .Clk(clk), .Rst(rst), .bus(bus0.slave)
    );
    conditional_negator_pipe #(.DataSize(DS), .Lanes(L), .Sat(1'b1)) dut1 (
        .Clk(clk), .Rst(rst), .bus(bus1.slave)
    );

    // Lane rules as signed integer arithmetic: out-of-range results flag overflow.
    function automatic logic [W+L-1:0] model(input logic [W-1:0] d, input logic [1:0] m,
                                             input logic [L-1:0] k, input bit sat);
        logic [W-1:0]  od;
        logic [L-1:0]  ov;
        logic [DS-1:0] lane;
        int x;
        int y;
        od = '0;
        ov = '0;
        for (int i = 0; i < int'(L); i++) begin
            lane = d[i*DS +: DS];
            x = int'($signed(lane));
            y = x;
            if (k[i]) begin
                case (m)
                    2'd1:    y = -x;
                    2'd2:    y = (x < 0) ? -x : x;
                    2'd3:    y = -x - 1;
                    default: y = x;
                endcase
            end
            if (y > MAXV) begin
                ov[i] = 1'b1;
                if (sat) y = MAXV;
            end
            od[i*DS +: DS] = DS'(y);
        end
        return {ov, od};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding input transfer.
    always @(negedge clk) begin
        logic [W+L-1:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus0.OutValid && out_ready) begin
                if (q0.size() == 0) chk("stream0_unexpected", 64'd1, 64'd0);
                else begin
                    e = q0.pop_front();
                    chk("stream0", 64'({bus0.OutOvf, bus0.OutData}), 64'(e));
                end
            end
            if (bus1.OutValid && out_ready) begin
                if (q1.size() == 0) chk("stream1_unexpected", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    chk("stream1", 64'({bus1.OutOvf, bus1.OutData}), 64'(e));
                end
            end
            if (in_valid && bus0.InReady) q0.push_back(model(in_data, mode, mask, 1'b0));
            if (in_valid && bus1.InReady) q1.push_back(model(in_data, mode, mask, 1'b1));
        end
    end

    task automatic send_check(input string nm, input logic [W-1:0] d, input logic [1:0] m,
                              input logic [L-1:0] k, input logic [W-1:0] e0,
                              input logic [W-1:0] e1, input logic [L-1:0] eo);
        @(posedge clk); #1;
        in_data = d; mode = m; mask = k; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_early"}, 64'(bus0.OutValid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid0"}, 64'(bus0.OutValid), 64'd1);
        chk({nm, "_valid1"}, 64'(bus1.OutValid), 64'd1);
        chk({nm, "_data0"}, 64'(bus0.OutData), 64'(e0));
        chk({nm, "_data1"}, 64'(bus1.OutData), 64'(e1));
        chk({nm, "_ovf0"}, 64'(bus0.OutOvf), 64'(eo));
        chk({nm, "_ovf1"}, 64'(bus1.OutOvf), 64'(eo));
    endtask

    task automatic drain(input string nm);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus0.OutValid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_drained"}, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic rand_word();
        logic [DS-1:0] lane;
        for (int i = 0; i < int'(L); i++) begin
            lane = DS'($urandom);
            if ($urandom_range(0, 3) == 0) lane = {1'b1, {(DS-1){1'b0}}};
            in_data[i*DS +: DS] = lane;
        end
        mode = 2'($urandom);
        mask = L'($urandom);
    endtask

    initial begin
        in_data = '0; mode = 2'b00; mask = '0; in_valid = 1'b0; out_ready = 1'b1;

        // Reset state, held regardless of the clock
        #2;
        chk("rst_outvalid", 64'(bus0.OutValid), 64'd0);
        chk("rst_outdata", 64'(bus0.OutData), 64'd0);
        chk("rst_outovf", 64'(bus1.OutOvf), 64'd0);
        chk("rst_inready", 64'(bus0.InReady), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("rst_held_outvalid", 64'(bus1.OutValid), 64'd0);
        #2 rst = 1'b0;
        chk("post_rst_inready", 64'(bus0.InReady), 64'd1);

        // Hand-computed pins on the model
        chk("model_neg_wrap", 64'(model(32'h8005FF00, 2'b01, 4'hF, 1'b0)), 64'h8_80FB0100);
        chk("model_neg_sat", 64'(model(32'h8005FF00, 2'b01, 4'hF, 1'b1)), 64'h8_7FFB0100);
        chk("model_abs_mask", 64'(model(32'hF6F6F6F6, 2'b10, 4'b0101, 1'b0)), 64'h0_F60AF60A);
        chk("model_inv", 64'(model(32'h00FF7F80, 2'b11, 4'hF, 1'b1)), 64'h0_FF00807F);

        // Directed vectors with latency checks
        send_check("neg", 32'h8005FF00, 2'b01, 4'hF, 32'h80FB0100, 32'h7FFB0100, 4'b1000);
        send_check("abs_mask", 32'hF6F6F6F6, 2'b10, 4'b0101, 32'hF60AF60A, 32'hF60AF60A, 4'b0000);
        send_check("abs_min_unmasked", 32'h80808080, 2'b10, 4'b0010, 32'h80808080, 32'h80807F80, 4'b0010);
        send_check("pass", 32'h80123456, 2'b00, 4'hF, 32'h80123456, 32'h80123456, 4'b0000);
        drain("directed");

        // Backpressure: two words fill the pipe, then input stalls
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; rand_word();
        @(negedge clk); chk("stall_c0_ready", 64'(bus0.InReady), 64'd1);
        @(posedge clk); #1; rand_word();
        @(negedge clk); chk("stall_c1_ready", 64'(bus0.InReady), 64'd1);
        @(posedge clk); #1; rand_word();
        @(negedge clk);
        chk("stall_c2_ready", 64'(bus0.InReady), 64'd0);
        chk("stall_c2_valid", 64'(bus0.OutValid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("stall_c3_ready", 64'(bus1.InReady), 64'd0);
        chk("stall_held", 64'(q0.size()), 64'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; rand_word();
        end
        drain("stall");

        // Reset with two words in flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; rand_word();
        @(posedge clk); #1; rand_word();
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus0.OutValid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid0", 64'(bus0.OutValid), 64'd0);
        chk("async_rst_valid1", 64'(bus1.OutValid), 64'd0);
        chk("async_rst_data", 64'(bus0.OutData), 64'd0);
        chk("async_rst_ready", 64'(bus0.InReady), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0; out_ready = 1'b1;
        chk("rst_release_ready", 64'(bus0.InReady), 64'd1);
        send_check("after_rst", 32'h00000000, 2'b11, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000);
        drain("after_rst");

        // Randomised traffic with random backpressure
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_word();
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
